// File: rtl/ce_frame_arb.sv
// ce_frame_arb: two-requester frame arbiter for the CE chain. Grants whole
// Avalon-ST frames round-robin and forwards them through one register stage.
// Latency 1 clk per beat. Backpressure: the granted port sees !m_valid || m_ready.
// Ports:
//   clk, rst             single clock; asynchronous active-high reset
//   s0_*/s1_*            requester framing (valid/ready/sop/eop), error,
//                        real/imag samples and frame length (fftpts)
//   m_*                  sink side; m_chan reports the granted requester
//   frame_done           pulses while the eop beat is taken on the m side
//   len_err              pulses with the beat that violated the frame length
// Optional build macro CE_ARB_LEN_CHECK_EN adds the frame-length checker.
module ce_frame_arb #(
  parameter int wData = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  input  logic             s0_sop,
  input  logic             s0_eop,
  output logic             s0_ready,
  input  logic [1:0]       s0_error,
  input  logic [wData-1:0] s0_real,
  input  logic [wData-1:0] s0_imag,
  input  logic [11:0]      s0_fftpts,
  input  logic             s1_valid,
  input  logic             s1_sop,
  input  logic             s1_eop,
  output logic             s1_ready,
  input  logic [1:0]       s1_error,
  input  logic [wData-1:0] s1_real,
  input  logic [wData-1:0] s1_imag,
  input  logic [11:0]      s1_fftpts,
  output logic             m_valid,
  output logic             m_sop,
  output logic             m_eop,
  input  logic             m_ready,
  output logic [1:0]       m_error,
  output logic [wData-1:0] m_real,
  output logic [wData-1:0] m_imag,
  output logic [11:0]      m_fftpts,
  output logic             m_chan,
  output logic             frame_done,
  output logic             len_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic        g, g_n;
  logic        rr, rr_n;
  logic [11:0] fftpts_q, fftpts_n;
  logic        first_q, first_n;   // next beat taken is the first of the frame
`ifdef CE_ARB_LEN_CHECK_EN
  logic [11:0] cnt_q, cnt_n;
`endif

  // Beat presented by the granted requester.
  logic             sel_valid, sel_sop, sel_eop;
  logic [1:0]       sel_err;
  logic [wData-1:0] sel_real, sel_imag;

  assign sel_valid = g ? s1_valid : s0_valid;
  assign sel_sop   = g ? s1_sop   : s0_sop;
  assign sel_eop   = g ? s1_eop   : s0_eop;
  assign sel_err   = g ? s1_error : s0_error;
  assign sel_real  = g ? s1_real  : s0_real;
  assign sel_imag  = g ? s1_imag  : s0_imag;

  logic c0, c1, win, out_free, acc, len_flag, force_eop;

  assign c0       = s0_valid & s0_sop;
  assign c1       = s1_valid & s1_sop;
  // Single candidate wins outright; on a tie the round-robin pointer decides.
  assign win      = (c0 & c1) ? rr : c1;
  assign out_free = !m_valid || m_ready;

  always_comb begin
    state_n   = state;
    g_n       = g;
    rr_n      = rr;
    fftpts_n  = fftpts_q;
    first_n   = first_q;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    acc       = 1'b0;
    len_flag  = 1'b0;
    force_eop = 1'b0;
`ifdef CE_ARB_LEN_CHECK_EN
    cnt_n     = cnt_q;
`endif
    case (state)
      IDLE: begin
        // Beats without sop cannot open a frame; swallow them.
        s0_ready = s0_valid & !s0_sop;
        s1_ready = s1_valid & !s1_sop;
        if (c0 | c1) begin
          state_n  = BUSY;
          g_n      = win;
          fftpts_n = win ? s1_fftpts : s0_fftpts;
          first_n  = 1'b1;
`ifdef CE_ARB_LEN_CHECK_EN
          cnt_n    = 12'd0;
`endif
        end
      end
      BUSY: begin
        if (g) s1_ready = out_free;
        else   s0_ready = out_free;
        acc = sel_valid & out_free;
        if (acc) begin
          first_n = 1'b0;
`ifdef CE_ARB_LEN_CHECK_EN
          cnt_n = cnt_q + 12'd1;
          if (sel_eop && (cnt_q + 12'd1 != fftpts_q)) len_flag = 1'b1;
          if (!sel_eop && (cnt_q + 12'd1 == fftpts_q)) begin
            force_eop = 1'b1;
            len_flag  = 1'b1;
          end
`endif
          if (sel_eop || force_eop) begin
            state_n = IDLE;
            rr_n    = !g;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Nothing is accepted while reset is held.
    if (rst) begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      g        <= 1'b0;
      rr       <= 1'b0;
      fftpts_q <= 12'd0;
      first_q  <= 1'b0;
`ifdef CE_ARB_LEN_CHECK_EN
      cnt_q    <= 12'd0;
`endif
    end else begin
      state    <= state_n;
      g        <= g_n;
      rr       <= rr_n;
      fftpts_q <= fftpts_n;
      first_q  <= first_n;
`ifdef CE_ARB_LEN_CHECK_EN
      cnt_q    <= cnt_n;
`endif
    end
  end

  // Output register stage: loads only on acceptance, so it holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_sop    <= 1'b0;
      m_eop    <= 1'b0;
      m_error  <= 2'b00;
      m_real   <= '0;
      m_imag   <= '0;
      m_fftpts <= 12'd0;
      m_chan   <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      len_err <= acc & len_flag;
      if (acc) begin
        m_valid  <= 1'b1;
        // A repeated sop inside a frame is demoted and flagged on error[0].
        m_sop    <= sel_sop & first_q;
        m_eop    <= sel_eop | force_eop;
        m_error  <= sel_err | {len_flag, sel_sop & !first_q};
        m_real   <= sel_real;
        m_imag   <= sel_imag;
        m_fftpts <= fftpts_q;
        m_chan   <= g;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign frame_done = m_valid & m_ready & m_eop;

endmodule

// File: tb/tb_ce_frame_arb.sv
module tb_ce_frame_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid [2];
  logic        s_sop   [2];
  logic        s_eop   [2];
  logic [1:0]  s_error [2];
  logic [15:0] s_real  [2];
  logic [15:0] s_imag  [2];
  logic [11:0] s_fft   [2];
  logic        s0_ready, s1_ready;
  logic        m_valid, m_sop, m_eop, m_ready, m_chan, frame_done, len_err;
  logic [1:0]  m_error;
  logic [15:0] m_real, m_imag;
  logic [11:0] m_fftpts;

  ce_frame_arb #(.wData(16)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s_valid[0]), .s0_sop(s_sop[0]), .s0_eop(s_eop[0]), .s0_ready(s0_ready),
    .s0_error(s_error[0]), .s0_real(s_real[0]), .s0_imag(s_imag[0]), .s0_fftpts(s_fft[0]),
    .s1_valid(s_valid[1]), .s1_sop(s_sop[1]), .s1_eop(s_eop[1]), .s1_ready(s1_ready),
    .s1_error(s_error[1]), .s1_real(s_real[1]), .s1_imag(s_imag[1]), .s1_fftpts(s_fft[1]),
    .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
    .m_error(m_error), .m_real(m_real), .m_imag(m_imag), .m_fftpts(m_fftpts),
    .m_chan(m_chan), .frame_done(frame_done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [48:0] v;
    int          c;
  } exp_t;

  exp_t sb[$];
  logic sop_log[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, done_cnt = 0, len_cnt = 0, exp_done = 0, exp_len = 0, fid = 0;
  bit   lat_chk = 1'b1, stalled = 1'b0, tog = 1'b0;
  logic [48:0] snap;
  logic        cur_chan = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Beat image: {chan, sop, eop, error[1:0], real, imag, fftpts}; eop is bit 46.
  function automatic logic [48:0] pk(logic chan, logic sop, logic eop, logic [1:0] err,
                                     logic [15:0] re, logic [15:0] im, logic [11:0] fft);
    return {chan, sop, eop, err, re, im, fft};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h (t=%0t)", nm, act, $time);
  endtask

  // Hold the current beat until the port takes it; returns just after that edge.
  task automatic send_beat(input int p);
    bit r;
    int n = 0;
    do begin
      @(negedge clk);
      r = (p == 1) ? s1_ready : s0_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 500);
    if (!r) fail("ready_timeout", 64'(p));
  endtask

  task automatic set_beat(input int p, input int i, input int fft, input bit sop,
                          input bit eop, input logic [1:0] errp);
    s_sop[p]   = sop;
    s_eop[p]   = eop;
    s_error[p] = errp;
    s_real[p]  = 16'(fid * 256 + p * 128 + i);
    s_imag[p]  = ~s_real[p];
    s_fft[p]   = 12'(fft);
    s_valid[p] = 1'b1;
  endtask

  // Send n beats; the first fwd_n are expected on m (the last of those as eop),
  // error[1] is expected at err1_at and error[0] at the repeated sop sop2_at.
  task automatic send_frame(input int p, input int n, input int fft, input int eop_at,
                            input int fwd_n, input int err1_at, input int sop2_at,
                            input logic [1:0] errp);
    exp_t e;
    fid++;
    for (int i = 0; i < n; i++) begin
      set_beat(p, i, fft, (i == 0) || (i == sop2_at), i == eop_at, errp);
      send_beat(p);
      if (i < fwd_n) begin
        e.v = pk(p[0], i == 0, i == fwd_n - 1, errp | {i == err1_at, i == sop2_at},
                 s_real[p], s_imag[p], 12'(fft));
        e.c = cyc;
        sb.push_back(e);
      end
    end
    s_valid[p] = 1'b0;
    s_sop[p]   = 1'b0;
    s_eop[p]   = 1'b0;
    if (fwd_n > 0) exp_done++;
  endtask

  task automatic drain();
    bit dr = 1'b0;
    for (int k = 0; k < 300 && !dr; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_valid) dr = 1'b1;
    end
    if (!dr) fail("drain_timeout", 64'(sb.size()));
  endtask

  // Monitor: pops the scoreboard on every m-side handshake.
  always @(negedge clk) begin
    logic [48:0] cur;
    exp_t e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      cur = pk(m_chan, m_sop, m_eop, m_error, m_real, m_imag, m_fftpts);
      if (stalled && m_valid) chk("stall_hold", 64'(cur), 64'(snap));
      if (frame_done) done_cnt++;
      if (len_err) len_cnt++;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          fail("unexpected_beat", 64'(cur));
        end else begin
          e = sb.pop_front();
          chk("beat", 64'(cur), 64'(e.v));
          chk("frame_done", 64'(frame_done), 64'(e.v[46]));
          if (lat_chk) chk("latency", 64'(cyc), 64'(e.c));
          if (m_sop) begin
            sop_log.push_back(m_chan);
            cur_chan = m_chan;
          end else begin
            chk("no_interleave", 64'(m_chan), 64'(cur_chan));
          end
        end
      end
      stalled = m_valid && !m_ready;
      snap    = cur;
    end
  end

  function automatic logic [53:0] outs();
    return {m_valid, m_sop, m_eop, m_error, m_chan, frame_done, len_err,
            s0_ready, s1_ready, m_real, m_imag, m_fftpts};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq;
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      s_valid[p] = 1'b0; s_sop[p] = 1'b0; s_eop[p] = 1'b0; s_error[p] = 2'b00;
      s_real[p] = '0; s_imag[p] = '0; s_fft[p] = '0;
    end
    m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'(outs()), 64'd0);
    rst = 1'b0;

    // Both requesters open frames at once: s0, then s1, then s0 again.
    fork
      begin
        send_frame(0, 8, 8, 7, 8, -1, -1, 2'b00);
        send_frame(0, 8, 8, 7, 8, -1, -1, 2'b00);
      end
      send_frame(1, 8, 8, 7, 8, -1, -1, 2'b00);
    join
    drain();
    seq = 8'd0;
    foreach (sop_log[i]) seq = {seq[6:0], sop_log[i]};
    chk("arb_order", {48'd0, 8'(sop_log.size()), seq}, {48'd0, 8'd3, 8'b010});

    // Long frame with m_ready held high.
    send_frame(0, 64, 64, 63, 64, -1, -1, 2'b00);
    drain();

    // m_ready toggling every cycle during a 16-beat frame.
    lat_chk = 1'b0;
    tog = 1'b1;
    fork
      begin
        send_frame(1, 16, 16, 15, 16, -1, -1, 2'b00);
        tog = 1'b0;
      end
      while (tog) begin
        @(posedge clk);
        #1;
        m_ready = !m_ready;
      end
    join
    m_ready = 1'b1;
    drain();
    lat_chk = 1'b1;

    // Repeated sop mid-frame plus error passthrough on bit 1.
    send_frame(1, 8, 8, 7, 8, -1, 3, 2'b10);
    drain();

    // Stray non-sop beats while idle are consumed and dropped.
    s_sop[1] = 1'b0; s_eop[1] = 1'b0; s_valid[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_real[1] = 16'(16'hA000 + i);
      @(negedge clk);
      chk("stray_ready", 64'(s1_ready), 64'd1);
      chk("stray_mvalid", 64'(m_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    s_valid[1] = 1'b0;
    @(negedge clk);
    chk("stray_mvalid_after", 64'(m_valid), 64'd0);

`ifdef CE_ARB_LEN_CHECK_EN
    // Early eop: flagged on beat 12 of a 16-point frame.
    send_frame(0, 12, 16, 11, 12, 11, -1, 2'b00);
    exp_len++;
    drain();
    // Missing eop: forced on beat 16; the trailing beats are strays.
    send_frame(0, 20, 16, -1, 16, 15, -1, 2'b00);
    exp_len++;
    drain();
`endif

    // Reset asserted during beat 5 of a 32-beat frame.
    fid++;
    for (int i = 0; i < 5; i++) begin
      set_beat(0, i, 32, i == 0, 1'b0, 2'b00);
      send_beat(0);
      e.v = pk(1'b0, i == 0, 1'b0, 2'b00, s_real[0], s_imag[0], 12'd32);
      e.c = cyc;
      sb.push_back(e);
    end
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async", 64'(outs()), 64'd0);
    sb.delete();
    s_valid[0] = 1'b0;
    s_sop[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(0, 8, 8, 7, 8, -1, -1, 2'b00);
    drain();

    chk("frame_done_count", 64'(done_cnt), 64'(exp_done));
    chk("len_err_count", 64'(len_cnt), 64'(exp_len));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
